// File: rtl/aes_pkg.sv
// Shared AES byte-layout helpers: byte extraction and the ShiftRows destination mapping.
package aes_pkg;
  localparam int AES_BYTES = 16;
  localparam int ROW_W     = 2;
  localparam int COL_W     = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} sbsr_state_e;

  // Byte j of the state, j = 4*col + row, byte 0 in the most significant position.
  function automatic logic [7:0] get_byte(input logic [127:0] st, input logic [3:0] j);
    return st[127 - 8*int'(j) -: 8];
  endfunction

  function automatic logic [3:0] sr_index(input logic [3:0] j, input logic inv);
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic [COL_W-1:0] cs;
    r  = j[1:0];
    c  = j[3:2];
    cs = inv ? (c + r) : (c - r);
    return {cs, r};
  endfunction
endpackage

// File: rtl/sbsr_tag_pipe.sv
// Tag shift register tracking {valid, last, destination indices} alongside the external S-box pipeline.
module sbsr_tag_pipe #(
  parameter int STAGES = 1,
  parameter int IDX_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_vld,
  input  logic             issue_last,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             tag_vld,
  output logic             tag_last,
  output logic [IDX_W-1:0] tag_idx
);
  logic             vld_p  [STAGES];
  logic             last_p [STAGES];
  logic [IDX_W-1:0] idx_p  [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_p[s]  <= 1'b0;
        last_p[s] <= 1'b0;
      end
    end else begin
      vld_p[0]  <= issue_vld;
      last_p[0] <= issue_last;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s]  <= vld_p[s-1];
        last_p[s] <= last_p[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= issue_idx;
    for (int s = 1; s < STAGES; s++) idx_p[s] <= idx_p[s-1];
  end

  assign tag_vld  = vld_p[STAGES-1];
  assign tag_last = last_p[STAGES-1];
  assign tag_idx  = idx_p[STAGES-1];
endmodule

// File: rtl/subbytes_shiftrows_lanes.sv
// SubBytes+ShiftRows (and inverse) engine issuing LANES bytes per grant to a shared pipelined S-box.
// Optional stall counter output enabled by defining SBSR_STALL_CNT_EN.
module subbytes_shiftrows_lanes
  import aes_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int SBOX_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               inv,
  input  logic [127:0]       state_in,
  output logic               busy,
  output logic               done,
  output logic               we,
  output logic [4*LANES-1:0] wr_idx,
  output logic [8*LANES-1:0] wr_data,
  output logic               sbox_req,
  input  logic               sbox_gnt,
  output logic               sbox_inv,
  output logic [8*LANES-1:0] sbox_in,
  input  logic [8*LANES-1:0] sbox_out
`ifdef SBSR_STALL_CNT_EN
  ,
  output logic [7:0]         stall_cnt
`endif
);
  localparam int         NGROUPS  = AES_BYTES / LANES;
  localparam logic [3:0] LAST_GRP = 4'(NGROUPS - 1);

  sbsr_state_e        state, state_nxt;
  logic [127:0]       snap;
  logic               inv_q;
  logic [3:0]         grp;
  logic               accept, issue, issue_last;
  logic [4*LANES-1:0] issue_idx;
  logic               tag_vld, tag_last;
  logic [4*LANES-1:0] tag_idx;

  assign accept     = (state == ST_IDLE) && start;
  assign busy       = (state != ST_IDLE);
  assign sbox_req   = (state == ST_ISSUE);
  assign sbox_inv   = busy && inv_q;
  assign issue      = sbox_req && sbox_gnt;
  assign issue_last = issue && (grp == LAST_GRP);

  // Issue stage: lane bytes and their post-ShiftRows destinations for the current group
  always_comb begin
    logic [3:0] j;
    j         = '0;
    sbox_in   = '0;
    issue_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      j = 4'(int'(grp) * LANES + l);
      issue_idx[4*l +: 4] = sr_index(j, inv_q);
      if (sbox_req) sbox_in[8*l +: 8] = get_byte(snap, j);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_nxt = ST_DRAIN;
      // Hold busy through the done cycle; return to IDLE one cycle later
      ST_DRAIN: if (done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) snap <= state_in;
  end

  sbsr_tag_pipe #(
    .STAGES (SBOX_LAT),
    .IDX_W  (4*LANES)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (issue),
    .issue_last (issue_last),
    .issue_idx  (issue_idx),
    .tag_vld    (tag_vld),
    .tag_last   (tag_last),
    .tag_idx    (tag_idx)
  );

  // Capture stage: S-box results meet their tags SBOX_LAT cycles after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grp     <= '0;
      inv_q   <= 1'b0;
      we      <= 1'b0;
      done    <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        inv_q <= inv;
        grp   <= '0;
      end else if (issue) begin
        grp <= grp + 4'd1;
      end
      we   <= tag_vld;
      done <= tag_vld && tag_last;
      if (tag_vld) begin
        wr_idx  <= tag_idx;
        wr_data <= sbox_out;
      end
    end
  end

`ifdef SBSR_STALL_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       stall_cnt <= '0;
    else if (accept)               stall_cnt <= '0;
    else if (sbox_req && !sbox_gnt) stall_cnt <= sat_inc(stall_cnt);
  end
`endif
endmodule

// File: tb/tb_subbytes_shiftrows_lanes.sv
// Directed bench for subbytes_shiftrows_lanes with a behavioural SBOX_LAT-deep S-box model.
module tb_subbytes_shiftrows_lanes;
  localparam int LANES    = 4;
  localparam int SBOX_LAT = 2;
  localparam int NG       = 16 / LANES;

  localparam logic [127:0] V_PLAIN = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] V_SBSR  = 128'h6353e08c0960e104cd70b751bacad0e7;

  logic clk = 1'b0;
  logic rst, start, inv, busy, done, we, sbox_req, sbox_gnt, sbox_inv;
  logic [127:0]       state_in;
  logic [4*LANES-1:0] wr_idx;
  logic [8*LANES-1:0] wr_data, sbox_in, sbox_out;
`ifdef SBSR_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subbytes_shiftrows_lanes #(.LANES(LANES), .SBOX_LAT(SBOX_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inv      (inv),
    .state_in (state_in),
    .busy     (busy),
    .done     (done),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .sbox_req (sbox_req),
    .sbox_gnt (sbox_gnt),
    .sbox_inv (sbox_inv),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
`ifdef SBSR_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  logic [0:255][7:0] sbox_flat;
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  // Behavioural S-box: results appear SBOX_LAT cycles after the issue edge; filler otherwise
  logic [8*LANES-1:0] sb_p [SBOX_LAT];
  always @(posedge clk) begin
    for (int s = SBOX_LAT - 1; s > 0; s--) sb_p[s] <= sb_p[s-1];
    for (int l = 0; l < LANES; l++)
      sb_p[0][8*l +: 8] <= (sbox_req && sbox_gnt) ?
        (sbox_inv ? isbox_t[sbox_in[8*l +: 8]] : sbox_t[sbox_in[8*l +: 8]]) : 8'h5A;
  end
  assign sbox_out = sb_p[SBOX_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor
  bit mon_clr = 1'b0;
  logic [7:0] asm_b [16];
  int hits [16];
  int we_pulses, done_cnt, first_we, last_we, done_cyc;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        for (int j = 0; j < 16; j++) begin asm_b[j] = 8'hEE; hits[j] = 0; end
        we_pulses = 0; done_cnt = 0; first_we = -1; last_we = -1; done_cyc = -1;
      end else begin
        if (we === 1'b1) begin
          for (int l = 0; l < LANES; l++) begin
            asm_b[wr_idx[4*l +: 4]] = wr_data[8*l +: 8];
            hits[wr_idx[4*l +: 4]]++;
          end
          if (we_pulses == 0) first_we = cyc;
          last_we = cyc;
          we_pulses++;
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  int st_cyc;

  function automatic logic [127:0] asm128();
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = asm_b[j];
    return r;
  endfunction

  function automatic logic [127:0] ref_sbsr(input logic [127:0] st, input logic iv);
    logic [127:0] o;
    logic [7:0] b;
    int sc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sc = iv ? (c - r + 4) % 4 : (c + r) % 4;
        b  = st[127 - 8*(4*sc + r) -: 8];
        o[127 - 8*(4*c + r) -: 8] = iv ? isbox_t[b] : sbox_t[b];
      end
    return o;
  endfunction

  task automatic start_pass(input logic [127:0] st, input logic iv);
    @(posedge clk); #1;
    start = 1'b1; state_in = st; inv = iv; mon_clr = 1'b1; st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin timed_out = 1'b0; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inv = 1'b0; state_in = '0; sbox_gnt = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, we, sbox_req, sbox_inv} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, we, sbox_req, sbox_inv});
    end
    checks++;
    if (wr_idx !== '0) begin errors++; $display("FAIL reset_wr_idx got %h want 0", wr_idx); end
    checks++;
    if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    checks++;
    if (sbox_in !== '0) begin errors++; $display("FAIL reset_sbox_in got %h want 0", sbox_in); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_encrypt();
    bit to;
    logic [8*LANES-1:0] exp_in;
    sbox_gnt = 1'b1;
    start_pass(V_PLAIN, 1'b0);
    for (int l = 0; l < LANES; l++) exp_in[8*l +: 8] = V_PLAIN[127 - 8*l -: 8];
    checks++;
    if ({busy, sbox_req, sbox_inv} !== 3'b110) begin
      errors++; $display("FAIL enc_issue_ctrl got %b want 110", {busy, sbox_req, sbox_inv});
    end
    checks++;
    if (sbox_in !== exp_in) begin errors++; $display("FAIL enc_sbox_in got %h want %h", sbox_in, exp_in); end
    wait_done(60, to);
    checks++;
    if (to) begin errors++; $display("FAIL enc_timeout got no done want done"); end
    checks++;
    if (done_cyc != st_cyc + NG + SBOX_LAT + 1) begin
      errors++; $display("FAIL enc_done_cycle got %0d want %0d", done_cyc - st_cyc, NG + SBOX_LAT + 1);
    end
    checks++;
    if (first_we != st_cyc + SBOX_LAT + 2) begin
      errors++; $display("FAIL enc_first_we got %0d want %0d", first_we - st_cyc, SBOX_LAT + 2);
    end
    checks++;
    if (asm128() !== V_SBSR) begin errors++; $display("FAIL enc_result got %h want %h", asm128(), V_SBSR); end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL enc_busy_after_done got %b want 00", {busy, done}); end
  endtask

  task automatic test_decrypt();
    bit to;
    sbox_gnt = 1'b1;
    start_pass(V_SBSR, 1'b1);
    checks++;
    if (sbox_inv !== 1'b1) begin errors++; $display("FAIL dec_sbox_inv got %b want 1", sbox_inv); end
    wait_done(60, to);
    checks++;
    if (to) begin errors++; $display("FAIL dec_timeout got no done want done"); end
    checks++;
    if (asm128() !== V_PLAIN) begin errors++; $display("FAIL dec_result got %h want %h", asm128(), V_PLAIN); end
    checks++;
    if (we_pulses != NG || last_we - first_we != NG - 1) begin
      errors++; $display("FAIL dec_back_to_back got pulses %0d span %0d want %0d %0d",
                         we_pulses, last_we - first_we, NG, NG - 1);
    end
  endtask

  task automatic test_stall();
    bit to;
    sbox_gnt = 1'b0;
    start_pass(V_PLAIN, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (we_pulses != 0) begin errors++; $display("FAIL stall_no_we got %0d want 0", we_pulses); end
    sbox_gnt = 1'b1;
    wait_done(60, to);
    checks++;
    if (to || done_cyc != st_cyc + 5 + NG + SBOX_LAT + 1) begin
      errors++; $display("FAIL stall_done_cycle got %0d want %0d", done_cyc - st_cyc, 5 + NG + SBOX_LAT + 1);
    end
    checks++;
    if (asm128() !== V_SBSR) begin errors++; $display("FAIL stall_result got %h want %h", asm128(), V_SBSR); end
`ifdef SBSR_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 8'd5) begin errors++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
`endif
  endtask

  task automatic test_toggle();
    bit to;
    logic [127:0] rs, exp;
    rs  = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_sbsr(rs, 1'b0);
    sbox_gnt = 1'b1;
    start_pass(rs, 1'b0);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin to = 1'b0; break; end
      sbox_gnt = ~sbox_gnt;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      inv      = ~inv;
    end
    @(negedge clk); #1;
    sbox_gnt = 1'b1;
    checks++;
    if (to) begin errors++; $display("FAIL toggle_timeout got no done want done"); end
    checks++;
    if (asm128() !== exp) begin errors++; $display("FAIL toggle_result got %h want %h", asm128(), exp); end
    checks++;
    if (we_pulses != NG || last_we - first_we != 2 * (NG - 1)) begin
      errors++; $display("FAIL toggle_we_pattern got pulses %0d span %0d want %0d %0d",
                         we_pulses, last_we - first_we, NG, 2 * (NG - 1));
    end
  endtask

  task automatic test_start_busy_rst();
    bit to;
    int pre;
    sbox_gnt = 1'b1;
    start_pass(V_PLAIN, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; state_in = '0; inv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, to);
    checks++;
    if (to || asm128() !== V_SBSR) begin
      errors++; $display("FAIL busy_start_result got %h want %h", asm128(), V_SBSR);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || we_pulses != NG) begin
      errors++; $display("FAIL busy_start_ignored got busy %b pulses %0d want 0 %0d", busy, we_pulses, NG);
    end
    start_pass({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    pre = we_pulses;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({we, done, busy, sbox_req} !== 4'b0) begin
      errors++; $display("FAIL rst_abort got %b want 0000", {we, done, busy, sbox_req});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (NG + SBOX_LAT + 4) @(negedge clk);
    #1;
    checks++;
    if (we_pulses != pre || done_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_late_writes got pulses %0d done %0d busy %b want %0d 0 0",
                         we_pulses, done_cnt, busy, pre);
    end
  endtask

  task automatic test_zero();
    bit to;
    int bad;
    sbox_gnt = 1'b1;
    start_pass('0, 1'b0);
    wait_done(60, to);
    checks++;
    if (to || asm128() !== {16{8'h63}}) begin
      errors++; $display("FAIL zero_result got %h want %h", asm128(), {16{8'h63}});
    end
    bad = 0;
    for (int j = 0; j < 16; j++) if (hits[j] != 1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL zero_idx_cover got %0d bad indices want 0", bad); end
  endtask

  initial begin
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_flat[i];
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    test_reset();
    test_encrypt();
    test_decrypt();
    test_stall();
    test_toggle();
    test_start_busy_rst();
    test_zero();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
